// File: rtl/pacman_gfx_pkg.sv
// Shared graphics constants for the pacman video path.
// Holds the colour palette, the on-screen map placement and the tile codes
// returned by the external map ROM.
package pacman_gfx_pkg;

    // Map placement on the 640x480 screen
    localparam int MAP_LU_X = 150;
    localparam int MAP_LU_Y = 50;
    localparam int MAP_W    = 348;
    localparam int MAP_H    = 408;

    // Palette (RGB332)
    localparam logic [7:0] COLOR_WALL   = 8'hD0;
    localparam logic [7:0] COLOR_BG     = 8'h00;
    localparam logic [7:0] COLOR_PACMAN = 8'hFC;
    localparam logic [7:0] COLOR_BLINKY = 8'hE0;
    localparam logic [7:0] COLOR_PINKY  = 8'hF3;
    localparam logic [7:0] COLOR_INKY   = 8'h1F;
    localparam logic [7:0] COLOR_CLYDE  = 8'hF4;

    // Map ROM tile codes
    typedef enum logic [1:0] {
        TILE_WALL  = 2'b00,
        TILE_PATH  = 2'b01,
        TILE_DOT   = 2'b10,
        TILE_POWER = 2'b11
    } tile_e;

endpackage

// File: rtl/sprite_hit.sv
// Combinational coverage test of one screen pixel against one square sprite.
// Ports:
//   en, in_map : sprite enable and "pixel lies inside the map" qualifier
//   x, y       : screen coordinates of the current pixel
//   sx, sy     : sprite centre in map space
//   hit        : pixel is covered by this sprite
module sprite_hit #(
    parameter int SPR_W    = 24,
    parameter int COORD_W  = 9,
    parameter int MAP_LU_X = pacman_gfx_pkg::MAP_LU_X,
    parameter int MAP_LU_Y = pacman_gfx_pkg::MAP_LU_Y
) (
    input  logic               en,
    input  logic               in_map,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    output logic               hit
);

    localparam logic [11:0] HALF = 12'(SPR_W / 2);
    localparam logic [11:0] LU_X = 12'(MAP_LU_X);
    localparam logic [11:0] LU_Y = 12'(MAP_LU_Y);

    logic [11:0] px, py, cx, cy;
    logic        in_x, in_y;

    assign px = {1'b0, x};
    assign py = {1'b0, y};
    assign cx = LU_X + 12'(sx);
    assign cy = LU_Y + 12'(sy);

    // The half-width is added on the pixel side instead of subtracted from the
    // centre, so a centre closer than SPR_W/2 to the map edge clips cleanly.
    assign in_x = (px + HALF >= cx) && (px < cx + HALF);
    assign in_y = (py + HALF >= cy) && (py < cy + HALF);
    assign hit  = en && in_map && in_x && in_y;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite-over-tile-map compositor with per-frame collision report.
// Ports:
//   clk, reset        : pixel clock, async active-low reset
//   x, y, pix_valid   : current screen pixel from the VGA timing generator
//   frame_end         : pulse after the last visible pixel of a frame
//   spr_en/x/y/color  : packed per-sprite enable, centre (map space), colour
//   map_x, map_y      : registered address to the external map ROM
//   map_pixel         : combinational ROM data for map_x/map_y
//   rgb, rgb_valid    : composited colour, 2 clocks after x/y
//   collision         : sprite i overlapped sprite 0 during last frame
//   wall_hit          : sprite i covered a wall during last frame
//   coll_valid        : pulse when collision/wall_hit are updated
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 24,
    parameter int COORD_W     = 9,
    parameter int MAP_LU_X    = pacman_gfx_pkg::MAP_LU_X,
    parameter int MAP_LU_Y    = pacman_gfx_pkg::MAP_LU_Y,
    parameter int MAP_W       = pacman_gfx_pkg::MAP_W,
    parameter int MAP_H       = pacman_gfx_pkg::MAP_H,
    parameter int COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] COLOR_WALL = COLOR_W'(pacman_gfx_pkg::COLOR_WALL),
    parameter logic [COLOR_W-1:0] COLOR_BG   = COLOR_W'(pacman_gfx_pkg::COLOR_BG)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [10:0]                    x,
    input  logic [10:0]                    y,
    input  logic                           pix_valid,
    input  logic                           frame_end,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES*COLOR_W-1:0] spr_color,
    output logic [COORD_W-1:0]             map_x,
    output logic [COORD_W-1:0]             map_y,
    input  logic [1:0]                     map_pixel,
    output logic [COLOR_W-1:0]             rgb,
    output logic                           rgb_valid,
    output logic [NUM_SPRITES-1:0]         collision,
    output logic [NUM_SPRITES-1:0]         wall_hit,
    output logic                           coll_valid
);

    import pacman_gfx_pkg::*;

    localparam int STAGES = 2;

    logic [11:0]            x12, y12;
    logic                   in_map0, in_map1;
    logic [NUM_SPRITES-1:0] hit0, hit1;
    logic [STAGES:1]        vld_pipe;
    logic [1:0]             fe_pipe;
    logic                   is_wall;
    logic [COLOR_W-1:0]     pix_rgb;
    logic [NUM_SPRITES-1:0] acc_coll, acc_wall, coll_term, wall_term;

    assign x12 = {1'b0, x};
    assign y12 = {1'b0, y};

    assign in_map0 = (x12 >= 12'(MAP_LU_X)) && (x12 < 12'(MAP_LU_X + MAP_W)) &&
                     (y12 >= 12'(MAP_LU_Y)) && (y12 < 12'(MAP_LU_Y + MAP_H));

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_hit #(
            .SPR_W   (SPR_W),
            .COORD_W (COORD_W),
            .MAP_LU_X(MAP_LU_X),
            .MAP_LU_Y(MAP_LU_Y)
        ) u_hit (
            .en    (spr_en[i]),
            .in_map(in_map0),
            .x     (x),
            .y     (y),
            .sx    (spr_x[i*COORD_W +: COORD_W]),
            .sy    (spr_y[i*COORD_W +: COORD_W]),
            .hit   (hit0[i])
        );
    end

    // map_pixel answers the address registered in stage 1, i.e. the pixel now in stage 2
    assign is_wall = (map_pixel == TILE_WALL);

    // Lowest set index wins: scan downwards so index 0 is applied last
    always_comb begin
        pix_rgb = COLOR_BG;
        if (in_map1) begin
            if (is_wall)
                pix_rgb = COLOR_WALL;
            for (int i = NUM_SPRITES - 1; i >= 0; i--)
                if (hit1[i])
                    pix_rgb = spr_color[i*COLOR_W +: COLOR_W];
        end
    end

    // Collision terms use raw hits, not the priority-resolved colour
    always_comb begin
        coll_term = '0;
        wall_term = '0;
        if (vld_pipe[1]) begin
            coll_term = hit1 & {NUM_SPRITES{hit1[0]}} & ~NUM_SPRITES'(1);
            if (is_wall)
                wall_term = hit1;
        end
    end

    assign rgb_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe   <= '0;
            in_map1    <= 1'b0;
            hit1       <= '0;
            map_x      <= '0;
            map_y      <= '0;
            rgb        <= '0;
            fe_pipe    <= '0;
            acc_coll   <= '0;
            acc_wall   <= '0;
            collision  <= '0;
            wall_hit   <= '0;
            coll_valid <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], pix_valid};
            in_map1  <= in_map0;
            hit1     <= hit0;
            map_x    <= COORD_W'(x12 - 12'(MAP_LU_X));
            map_y    <= COORD_W'(y12 - 12'(MAP_LU_Y));
            if (vld_pipe[1])
                rgb <= pix_rgb;

            // Delay frame_end so the frame's last pixel has left stage 2
            fe_pipe    <= {fe_pipe[0], frame_end};
            coll_valid <= fe_pipe[1];
            if (fe_pipe[1]) begin
                collision <= acc_coll | coll_term;
                wall_hit  <= acc_wall | wall_term;
                acc_coll  <= '0;
                acc_wall  <= '0;
            end else begin
                acc_coll <= acc_coll | coll_term;
                acc_wall <= acc_wall | wall_term;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, latency, priority, clipping,
// wall colouring and per-frame collision / wall-hit reporting.
module tb_sprite_compositor;

    localparam int N   = 4;
    localparam int CW  = 9;
    localparam int COW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [10:0]     x = '0, y = '0;
    logic            pix_valid = 1'b0, frame_end = 1'b0;
    logic [N-1:0]    spr_en = '0;
    logic [N*CW-1:0] spr_x = '0, spr_y = '0;
    logic [N*COW-1:0] spr_color = '0;
    logic [CW-1:0]   map_x, map_y;
    logic [1:0]      map_pixel;
    logic [COW-1:0]  rgb;
    logic            rgb_valid;
    logic [N-1:0]    collision, wall_hit;
    logic            coll_valid;

    // Map ROM model: 0 = all path, 1 = all wall, 2 = single wall tile
    logic [1:0]      map_mode = 2'd0;
    logic [CW-1:0]   wall_mx = '0, wall_my = '0;

    assign map_pixel = (map_mode == 2'd1) ? 2'b00 :
                       (map_mode == 2'd2 && map_x == wall_mx && map_y == wall_my) ? 2'b00 : 2'b01;

    int total = 0;
    int bad   = 0;

    sprite_compositor #(.NUM_SPRITES(N), .COORD_W(CW), .COLOR_W(COW)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .pix_valid(pix_valid),
        .frame_end(frame_end), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
        .spr_color(spr_color), .map_x(map_x), .map_y(map_y), .map_pixel(map_pixel),
        .rgb(rgb), .rgb_valid(rgb_valid), .collision(collision), .wall_hit(wall_hit),
        .coll_valid(coll_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_spr(input int i, input int sx, input int sy, input logic en);
        spr_x[i*CW +: CW] = CW'(sx);
        spr_y[i*CW +: CW] = CW'(sy);
        spr_en[i]         = en;
    endtask

    // One isolated pixel; called at a negedge, returns at a negedge
    task automatic pix(input string tag, input int px, input int py, input logic [7:0] exp);
        x = 11'(px); y = 11'(py); pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(rgb_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(rgb_valid), 32'd1);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    // Back-to-back pixels over a map-space rectangle
    task automatic scan(input int mx0, input int mx1, input int my0, input int my1);
        for (int yy = my0; yy <= my1; yy++)
            for (int xx = mx0; xx <= mx1; xx++) begin
                x = 11'(150 + xx); y = 11'(50 + yy); pix_valid = 1'b1;
                @(negedge clk);
            end
        pix_valid = 1'b0;
    endtask

    task automatic end_frame(input string tag, input logic check_vals,
                             input logic [N-1:0] ec, input logic [N-1:0] ew);
        logic got;
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (coll_valid) got = 1'b1;
        end
        chk({tag, "_cv"}, 32'(got), 32'd1);
        if (check_vals) begin
            chk({tag, "_coll"}, 32'(collision), 32'(ec));
            chk({tag, "_wall"}, 32'(wall_hit), 32'(ew));
        end
        @(negedge clk);
        chk({tag, "_cv_pulse"}, 32'(coll_valid), 32'd0);
    endtask

    initial begin
        spr_color = {8'h55, 8'hAA, 8'h77, 8'h3F};

        // Reset held with live pixels
        map_mode = 2'd1;
        x = 11'd200; y = 11'd60; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rgb",   32'(rgb),        32'd0);
        chk("rst_rv",    32'(rgb_valid),  32'd0);
        chk("rst_cv",    32'(coll_valid), 32'd0);
        chk("rst_coll",  32'(collision),  32'd0);
        chk("rst_wall",  32'(wall_hit),   32'd0);
        chk("rst_mapx",  32'(map_x),      32'd0);
        pix_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // First pixel after release; also checks 2-cycle latency
        pix("wall_on", 200, 60, 8'hD0);
        chk("map_x", 32'(map_x), 32'd50);
        chk("map_y", 32'(map_y), 32'd10);
        map_mode = 2'd0;
        pix("wall_off", 200, 60, 8'h00);
        map_mode = 2'd1;
        pix("offmap", 100, 60, 8'h00);

        // Priority: sprites 0 and 1 share a centre
        map_mode = 2'd0;
        set_spr(0, 100, 100, 1'b1);
        set_spr(1, 100, 100, 1'b1);
        pix("prio_0", 250, 150, 8'h3F);
        pix("prio_edge", 261, 161, 8'h3F);
        pix("prio_out", 262, 161, 8'h00);
        spr_en[0] = 1'b0;
        pix("prio_1", 250, 150, 8'h77);

        // Clipping at the map's top-left corner; wall shows where sprite ends
        map_mode = 2'd1;
        set_spr(1, 5, 5, 1'b1);
        pix("clip_lu",    150, 50, 8'h77);
        pix("clip_off",   149, 50, 8'h00);
        pix("clip_right", 166, 50, 8'h77);
        pix("clip_past",  167, 50, 8'hD0);
        pix("clip_ypast", 150, 67, 8'hD0);

        // Drop whatever the directed pixels accumulated
        end_frame("flush", 1'b0, '0, '0);

        // Collision: 0 and 2 overlap, 3 far away, 1 disabled
        map_mode = 2'd0;
        set_spr(0, 100, 100, 1'b1);
        set_spr(1, 300, 300, 1'b0);
        set_spr(2, 110, 100, 1'b1);
        set_spr(3, 200, 200, 1'b1);
        scan(80, 130, 90, 110);
        end_frame("coll_f1", 1'b1, 4'b0100, 4'b0000);
        set_spr(2, 300, 300, 1'b1);
        scan(80, 130, 90, 110);
        end_frame("coll_f2", 1'b1, 4'b0000, 4'b0000);

        // Wall on the very last pixel of the frame, covered by sprite 1
        spr_en = '0;
        set_spr(1, 50, 50, 1'b1);
        map_mode = 2'd2;
        wall_mx = 9'd50; wall_my = 9'd50;
        scan(30, 50, 50, 50);
        end_frame("wall_f1", 1'b1, 4'b0000, 4'b0010);
        wall_mx = 9'd30;
        scan(30, 50, 50, 50);
        end_frame("wall_f2", 1'b1, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
